gb_stream_src: RTL
==================

GB_STREAM_SRC -- requirements
Module: gb_stream_src

Interface
REQ-001 The block SHALL have parameter IMG_W, default 648, meaning pixels per row.
REQ-002 The block SHALL have parameter IMG_H, default 488, meaning rows per frame.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), meaning staging FIFO entries.
REQ-004 The block SHALL have port clk  in  1  clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port start  in  1  one-cycle pulse that begins a frame.
REQ-007 The block SHALL have port in_data  in  8  host pixel.
REQ-008 The block SHALL have port in_valid  in  1  host pixel valid.
REQ-009 The block SHALL have port in_ready  out  1  FIFO can accept a pixel.
REQ-010 The block SHALL have port m_TDATA  out  8  pixel to the blur accelerator input stream.
REQ-011 The block SHALL have port m_TVALID  out  1  m_TDATA valid.
REQ-012 The block SHALL have port m_TREADY  in  1  accelerator accepts.
REQ-013 The block SHALL have port m_TUSER  out  1  first pixel of the frame.
REQ-014 The block SHALL have port m_TLAST  out  1  last pixel of the frame.
REQ-015 The block SHALL have port busy  out  1  state is not IDLE.
REQ-016 The block SHALL have port frame_done  out  1  one-cycle pulse after the last beat.

Function
REQ-017 FSM states SHALL be IDLE, STREAM, DONE; start in IDLE moves to STREAM next cycle; start in STREAM/DONE is ignored.
REQ-018 FIFO push SHALL occur when in_valid && in_ready, in every state; in_ready = !full.
REQ-019 m_TVALID SHALL equal (state==STREAM) && !empty; m_TDATA is the FIFO head.
REQ-020 A beat SHALL occur when m_TVALID && m_TREADY; each beat pops the FIFO.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged; push when full is refused; no pop when empty.
REQ-022 A pixel pushed into an empty FIFO SHALL appear on m_TDATA the following cycle (1-cycle latency).
REQ-023 m_TDATA, m_TUSER and m_TLAST SHALL be held stable while m_TVALID && !m_TREADY.
REQ-024 The col counter (10 bits) SHALL advance on each beat and wrap at IMG_W-1 to 0, incrementing row (9 bits).
REQ-025 m_TUSER SHALL be high iff col==0 && row==0; m_TLAST SHALL be high iff col==IMG_W-1 && row==IMG_H-1.
REQ-026 The beat with m_TLAST SHALL move STREAM to DONE; DONE SHALL assert frame_done for exactly one cycle and return to IDLE.
REQ-027 Entering STREAM SHALL clear col and row to 0; FIFO contents are kept across frames.

Reset
REQ-028 rst SHALL force IDLE, empty FIFO, col=row=0, and in_ready=1, m_TVALID=0, m_TUSER=0 (m_TVALID gated), m_TLAST=0, busy=0, frame_done=0 in the next cycle.
REQ-029 rst mid-frame SHALL abort the frame with no frame_done pulse; m_TDATA is don't-care while m_TVALID=0.

Configuration
REQ-030 With GB_STREAM_SRC_STALL_CNT_EN defined, output stall_cnt (16 bits) SHALL count cycles with m_TVALID && !m_TREADY, saturate at 65535, clear on start and on rst.
REQ-031 Without GB_STREAM_SRC_STALL_CNT_EN, port stall_cnt and its logic SHALL be absent.

Structure
REQ-032 Package gb_pkg SHALL hold pix_t (8-bit), IMG_W/IMG_H default constants, and the FSM state enum.
REQ-033 The FIFO SHALL be sub-module gb_src_fifo (push/pop/full/empty/head); FSM and counters live in gb_stream_src.

Verification (IMG_W=4, IMG_H=2, FIFO_DEPTH=4)
REQ-034 Push 8 pixels 0x10..0x17, start, m_TREADY=1 -> 8 beats 0x10..0x17, m_TUSER on 0x10 only, m_TLAST on 0x17 only, frame_done pulse one cycle later.
REQ-035 Push 5 pixels with no start -> in_ready=0 after 4 accepted, m_TVALID=0, busy=0.
REQ-036 m_TREADY=0 for 3 cycles mid-frame -> m_TDATA held stable, no counter advance, stall_cnt=3 when macro defined.
REQ-037 Empty FIFO in STREAM, push 0xAB -> m_TVALID=1 with m_TDATA=0xAB next cycle.
REQ-038 rst after 3 beats -> IDLE, FIFO empty, no frame_done; a fresh start frame begins with m_TUSER on first beat.
REQ-039 start asserted during STREAM -> ignored, beat sequence and counters unaffected.

Source files
------------

// File: rtl/gb_pkg.sv
// rtl/gb_pkg.sv - shared pixel type, default frame geometry and source FSM states
package gb_pkg;

  typedef logic [7:0] pix_t;

  localparam int GB_IMG_W = 648;
  localparam int GB_IMG_H = 488;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/gb_src_fifo.sv
// rtl/gb_src_fifo.sv - staging FIFO between host pixel port and accelerator stream
import gb_pkg::*;

module gb_src_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_push_data,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output logic [7:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  pix_t        r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  // Advance pointers; a refused push or an empty pop leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say they are written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/gb_stream_src.sv
// rtl/gb_stream_src.sv - frame source for the blur accelerator; optional stall counter via GB_STREAM_SRC_STALL_CNT_EN
import gb_pkg::*;

module gb_stream_src #(
  parameter int IMG_W      = GB_IMG_W,
  parameter int IMG_H      = GB_IMG_H,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  m_TDATA,
  output logic        m_TVALID,
  input  logic        m_TREADY,
  output logic        m_TUSER,
  output logic        m_TLAST,
  output logic        busy,
  output logic        frame_done
`ifdef GB_STREAM_SRC_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
  localparam logic [8:0] ROW_LAST = 9'(IMG_H - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [9:0] r_col;
  logic [8:0] r_row;

  logic       w_full;
  logic       w_empty;
  logic       w_beat;
  logic       w_first_pos;
  logic       w_last_pos;
  logic       w_accept_start;

  gb_src_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (in_valid),
    .i_push_data (in_data),
    .i_pop       (w_beat),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (m_TDATA)
  );

  assign in_ready       = !w_full;
  assign w_beat         = m_TVALID && m_TREADY;
  assign w_first_pos    = (r_col == 10'd0) && (r_row == 9'd0);
  assign w_last_pos     = (r_col == COL_LAST) && (r_row == ROW_LAST);
  assign w_accept_start = (r_state == ST_IDLE) && start;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: start only counts from IDLE, the last beat ends the frame, DONE lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_beat && w_last_pos) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: frame markers are gated by valid so nothing stray shows while idle or starved.
  always_comb begin
    m_TVALID   = (r_state == ST_STREAM) && !w_empty;
    m_TUSER    = m_TVALID && w_first_pos;
    m_TLAST    = m_TVALID && w_last_pos;
    busy       = (r_state != ST_IDLE);
    frame_done = (r_state == ST_DONE);
  end

  // Raster position: cleared on an accepted start, advanced only by beats so stalls hold it.
  always_ff @(posedge clk) begin
    if (rst || w_accept_start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_beat) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? 9'd0 : r_row + 9'd1;
      end else begin
        r_col <= r_col + 10'd1;
      end
    end
  end

`ifdef GB_STREAM_SRC_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  assign stall_cnt = r_stall_cnt;

  // Back-pressure cycles of the current frame, saturating rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst || w_accept_start) begin
      r_stall_cnt <= '0;
    end else if (m_TVALID && !m_TREADY && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
